// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, J-type opcode and field positions.
package cpu_pkg;
  localparam int INST_W = 32;

  typedef logic [INST_W-1:0] inst_t;

  localparam logic [5:0] OPCODE_J = 6'b000010;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int JTARGET_MSB = 25;
  localparam int JTARGET_LSB = 0;
endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer with occupancy count; flush empties it in one cycle.
// Head data reads as zero whenever the buffer is empty.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     valid,
  output logic                     full,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // Storage needs no reset: contents are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rdata = valid ? mem[rd_ptr] : '0;
  assign count = count_q;
endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fetch PC, combinational ROM interface and a small queue.
// Optional J-type predecode steering is enabled by PREFETCH_JUMP_PREDECODE_EN.
module prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  next_pc;
  logic               push;
  logic               pop;
  logic               full;
  logic               q_valid;
  logic [ENTRY_W-1:0] head;

  // Redirect suppresses both queue operations; a pop frees a slot for a push at full.
  assign pop      = q_valid & out_ready & ~redirect;
  assign push     = ~redirect & (~full | pop);
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    next_pc = pc_plus4;
`ifdef PREFETCH_JUMP_PREDECODE_EN
    if (imem_data[OPCODE_MSB:OPCODE_LSB] == OPCODE_J) begin
      next_pc = {pc_plus4[ADDR_W-1:28], imem_data[JTARGET_MSB:JTARGET_LSB], 2'b00};
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      pc_q <= next_pc;
    end
  end

  inst_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_queue (
    .clk   (Clock),
    .rst   (Reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, imem_data}),
    .valid (q_valid),
    .full  (full),
    .rdata (head),
    .count (count)
  );

  assign imem_addr          = pc_q;
  assign out_valid          = q_valid;
  assign {out_pc, out_inst} = head;
endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: driver steps scenarios, a negedge monitor
// checks every consumed instruction against an expected queue.
module tb_prefetch_unit;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;
  logic              jump_mode;

  int vectors     = 0;
  int miscompares = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W-1:0]  jump_next;

  prefetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .count       (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, required finished");
    $fatal(1);
  end

  // ROM model: opcode field 101000 everywhere except the optional jump at 0.
  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a, input logic jm);
    if (jm && a == '0) return 32'h0800_0005;
    return {8'hA0, a[23:0]};
  endfunction

  always_comb imem_data = rom_word(imem_addr, jump_mode);

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [ADDR_W-1:0] pc);
    exp_q.push_back({pc, rom_word(pc, jump_mode)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: a consumed head must match the front of exp_q
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect) begin
      logic [ADDR_W+31:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got pc 0x%0h inst 0x%0h, required no pop", out_pc, out_inst);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_inst} !== e) begin
          miscompares++;
          $display("FAIL pop_data: got pc 0x%0h inst 0x%0h, required pc 0x%0h inst 0x%0h",
                   out_pc, out_inst, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  initial begin
`ifdef PREFETCH_JUMP_PREDECODE_EN
    jump_next = 32'h14;
`else
    jump_next = 32'h4;
`endif
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; jump_mode = 1'b0;
    step(2);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc", out_pc, 0);
    check("rst_inst", out_inst, 0);
    check("rst_imem_addr", imem_addr, 0);

    // streaming with out_ready=1: one entry in flight, pc advances by 4
    for (int i = 0; i < 7; i++) exp_push(ADDR_W'(4 * i));
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_count", 32'(count), 1);
    end
    rst = 1'b1; out_ready = 1'b0;
    step(1);
    rst = 1'b0;

    // stall: fill to DEPTH and hold
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("fill_count", 32'(count), (i < 4) ? 32'(i) : 32'd4);
    end
    check("stall_imem_addr", imem_addr, 32'h10);
    check("stall_head_pc", out_pc, 0);
    check("stall_valid", 32'(out_valid), 1);

    // drain while refilling at full: order held across pointer wrap
    for (int i = 0; i < 8; i++) exp_push(ADDR_W'(4 * i));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("wrap_count", 32'(count), 4);
      check("wrap_pc", out_pc, 32'(4 * (i + 1)));
    end

    // redirect while full, with a misaligned target
    redirect = 1'b1; redirect_pc = 32'h43;
    step(1);
    redirect = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_imem_addr", imem_addr, 32'h40);
    exp_push(32'h40);
    step(1);
    check("redir_valid", 32'(out_valid), 1);
    check("redir_pc", out_pc, 32'h40);
    check("redir_count", 32'(count), 1);
    step(1);
    check("redir_next_pc", out_pc, 32'h44);
    out_ready = 1'b0;

    // reset beats redirect on a full queue
    step(3);
    check("full2_count", 32'(count), 4);
    check("full2_imem_addr", imem_addr, 32'h54);
    step(1);
    check("stall2_imem_addr", imem_addr, 32'h54);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step(1);
    rst = 1'b0; redirect = 1'b0;
    check("rst_redir_count", 32'(count), 0);
    check("rst_redir_valid", 32'(out_valid), 0);
    check("rst_redir_imem_addr", imem_addr, 0);
    step(1);
    check("rst_redir_pc", out_pc, 0);
    check("rst_redir_valid1", 32'(out_valid), 1);

    // jump word at address 0
    rst = 1'b1; jump_mode = 1'b1;
    step(1);
    exp_push(32'h0);
    exp_push(jump_next);
    rst = 1'b0; out_ready = 1'b1;
    step(1);
    check("jump_head_pc", out_pc, 0);
    check("jump_head_inst", out_inst, 32'h0800_0005);
    check("jump_imem_addr", imem_addr, jump_next);
    step(1);
    check("jump_next_pc", out_pc, jump_next);
    step(1);
    check("jump_after_pc", out_pc, jump_next + 32'h4);
    out_ready = 1'b0;

    step(2);
    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
